fir_decim_out: RTL and testbench

Output stage that sits directly downstream of the high-pass FIR filter. It consumes the filter's 16-bit signed output stream and block-averages every DECIM valid samples (decimation). Each average is scaled and saturated to WIDTH_OUT bits, then buffered in a small FIFO that is drained through a valid/ready handshake by the next consumer.

---
 rtl/fir_decim_out.sv | 132 +++++++++++++
 tb/tb_fir_decim_out.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_out.sv
// Decimating output stage for the high-pass FIR: block-averages DECIM valid
// samples, scales and saturates to WIDTH_OUT bits, and buffers results in a FIFO.
module fir_decim_out #(
  parameter int WIDTH_IN   = 16,
  parameter int WIDTH_OUT  = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [WIDTH_IN-1:0]        in_data,
  input  logic                              in_valid,
  output logic signed [WIDTH_OUT-1:0]       out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = WIDTH_IN + LOG2D;
  localparam int SH    = LOG2D + SHIFT;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;

  localparam logic [LOG2D-1:0] LAST_PHASE = LOG2D'(DECIM - 1);
  localparam logic [LW-1:0]    FULL_LEVEL = LW'(FIFO_DEPTH);

  localparam logic [WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  localparam logic [WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

  // Saturation bounds sign-extended to accumulator width for comparison.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH_OUT){1'b0}}, OUT_MAX};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH_OUT){1'b1}}, OUT_MIN};

  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [LOG2D-1:0]            phase_q, phase_d;
  logic [WIDTH_OUT-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]               level_q, level_d;
  logic                        out_valid_q, out_valid_d;
  logic                        overflow_q, overflow_d;

  logic signed [ACC_W-1:0]     in_ext;
  logic signed [ACC_W-1:0]     sum;
  logic signed [ACC_W-1:0]     shifted;
  logic [WIDTH_OUT-1:0]        res_sat;
  logic                        block_done;
  logic                        pop;
  logic                        push;

  // DECIM samples of WIDTH_IN bits always fit in WIDTH_IN+log2(DECIM) bits,
  // so the final sum cannot wrap at accumulator width.
  always_comb begin
    in_ext  = {{LOG2D{in_data[WIDTH_IN-1]}}, in_data};
    sum     = acc_q + in_ext;
    shifted = sum >>> SH;
    res_sat = shifted[WIDTH_OUT-1:0];
    if (shifted > SAT_MAX) begin
      res_sat = OUT_MAX;
    end else if (shifted < SAT_MIN) begin
      res_sat = OUT_MIN;
    end
  end

  always_comb begin
    acc_d      = acc_q;
    phase_d    = phase_q;
    block_done = 1'b0;
    if (in_valid) begin
      if (phase_q == LAST_PHASE) begin
        block_done = 1'b1;
        acc_d      = '0;
        phase_d    = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + LOG2D'(1);
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop        = out_valid_q & out_ready;
    push       = block_done & ((level_q != FULL_LEVEL) | pop);
    overflow_d = overflow_q | (block_done & ~push);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    out_valid_d = (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      phase_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: the head is only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= res_sat;
    end
  end

  assign out_data   = out_valid_q ? mem_q[rd_ptr_q] : '0;
  assign out_valid  = out_valid_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out (DECIM=4, SHIFT=4, WIDTH_OUT=8, FIFO_DEPTH=4):
// expected averages are queued as samples are driven and checked as they drain.
module tb_fir_decim_out;

  logic               clk;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         fifo_level;
  logic               overflow;

  logic [7:0] exp_q[$];
  int n_cmp;
  int n_fail;

  fir_decim_out #(
    .WIDTH_IN(16), .WIDTH_OUT(8), .DECIM(4), .SHIFT(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: mean of four samples, further divided by 16, floored, clamped.
  function automatic logic [7:0] model(input int a, input int b, input int c, input int d);
    int s;
    int r;
    s = a + b + c + d;
    r = s >>> 6;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are read on falling edges.
  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic block4(input int a, input int b, input int c, input int d, input bit expect_push);
    if (expect_push) exp_q.push_back(model(a, b, c, d));
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_drained(input string name);
    idle(8);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results still expected, required 0", name, exp_q.size());
    end
  endtask

  // Scoreboard: compares each accepted head against the expected queue.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got %0d, required no output", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              n_fail++;
              $display("FAIL out_data: got %0d, required %0d", out_data, $signed(e));
            end
          end
        end else if (!out_valid) begin
          n_cmp++;
          if (out_data !== 8'sd0) begin
            n_fail++;
            $display("FAIL empty_out_data: got %0d, required 0", out_data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, fifo_level, out_data, overflow} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b level=%0d data=%0d ovf=%b, required all 0",
               out_valid, fifo_level, out_data, overflow);
    end
    idle(1);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    block4(100, 200, 300, 400, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid=%b, required 1", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: out_valid=%b, required 0", out_valid);
    end
    idle(1);
    check_drained("basic");
  endtask

  task automatic test_neg_sat();
    out_ready = 1'b1;
    exp_q.push_back(8'hF9);
    block4(-100, -100, -100, -100, 1'b0);
    exp_q.push_back(8'h7F);
    block4(32767, 32767, 32767, 32767, 1'b0);
    exp_q.push_back(8'h80);
    block4(-32768, -32768, -32768, -32768, 1'b0);
    check_drained("neg_sat");
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    exp_q.push_back(model(16, 16, 16, 16));
    for (int s = 0; s < 3; s++) begin
      send(16);
      for (int g = 0; g < 3; g++) begin
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_valid: out_valid=%b after sample %0d, required 0", out_valid, s);
        end
        @(posedge clk);
        #1;
      end
    end
    send(16);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_output: out_valid=%b, required 1", out_valid);
    end
    idle(1);
    check_drained("gaps");
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) block4(16 * k, 16 * k, 16 * k, 16 * k, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_level: level=%0d ovf=%b, required 4 and 0", fifo_level, overflow);
    end
    idle(1);
    block4(80, 80, 80, 80, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: level=%0d ovf=%b, required 4 and 1", fifo_level, overflow);
    end
    idle(1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_valid: out_valid=%b on pop %0d, required 1", out_valid, i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL after_drain: valid=%b level=%0d ovf=%b, required 0 0 1",
               out_valid, fifo_level, overflow);
    end
    idle(1);
    check_drained("overflow");
  endtask

  task automatic test_full_pop();
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) block4(16 * k, 16 * k, 16 * k, 16 * k, 1'b1);
    exp_q.push_back(model(80, 80, 80, 80));
    send(80);
    send(80);
    send(80);
    out_ready = 1'b1;
    send(80);
    @(negedge clk);
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop: level=%0d ovf=%b, required 4 and 0", fifo_level, overflow);
    end
    idle(1);
    check_drained("full_pop");
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    block4(64, 64, 64, 64, 1'b0);
    block4(128, 128, 128, 128, 1'b0);
    send(1000);
    send(1000);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, fifo_level, out_data, overflow} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b level=%0d data=%0d ovf=%b, required all 0",
               out_valid, fifo_level, out_data, overflow);
    end
    idle(1);
    out_ready = 1'b1;
    exp_q.push_back(8'd10);
    block4(160, 160, 160, 160, 1'b0);
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    int s [4];
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 4; i++) s[i] = int'($urandom_range(0, 65535)) - 32768;
      exp_q.push_back(model(s[0], s[1], s[2], s[3]));
      for (int i = 0; i < 4; i++) begin
        send(s[i]);
        idle(int'($urandom_range(0, 2)));
      end
    end
    check_drained("back_to_back");
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_neg_sat();
    test_gaps();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
